// File: rtl/ma_access_ctrl.sv
// ma_access_ctrl
//   Memory-access sequencer between the MA pipeline stage and the word-wide
//   data memory port. One load/store request becomes one or two word-aligned
//   bus transactions; an access that crosses a word boundary needs two. The
//   returned words are held in ld_word_lo/ld_word_hi so the load-data formatter
//   can merge them.
//
// Ports
//   clk, rst_n          system clock (rising edge), async active-low reset
//   req_valid           MA stage has a memory op, held until done
//   req_we              1 = store, 0 = load
//   req_addr[31:0]      byte address
//   req_len[1:0]        `MA_LEN_1B / `MA_LEN_2B / `MA_LEN_4B (code 3 acts as 4B)
//   req_wdata[31:0]     store data, right-justified
//   mem_req/addr/we/be/wdata   bus request, word address, write, lanes, data
//   mem_gnt             request accepted this cycle
//   mem_rvalid/rdata    read data return (loads only)
//   ma_stall            pipeline hold, req_valid & ~done
//   ma_second           second word of a split load is being returned
//   done                one-cycle completion pulse
//   ld_word_lo/hi       first / second returned word (hi = 0 if not split)
//   misalign_exc        misalignment exception
//
// Build option
//   MA_MISALIGN_TRAP_EN  a word-crossing request raises misalign_exc with done
//                        and issues no bus traffic. Undefined: misalign_exc = 0.
//
// state | meaning
// IDLE  | waiting for req_valid; request latched on acceptance
// REQ1  | first word request on the bus, held until mem_gnt
// WAIT1 | load: waiting for the first word
// REQ2  | second word request (word address + 1), held until mem_gnt
// WAIT2 | load: waiting for the second word
// RESP  | done pulse, back to IDLE

`ifndef MA_LEN_1B
`define MA_LEN_1B 2'd0
`endif
`ifndef MA_LEN_2B
`define MA_LEN_2B 2'd1
`endif
`ifndef MA_LEN_4B
`define MA_LEN_4B 2'd2
`endif

module ma_access_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_len,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        ma_stall,
  output logic        ma_second,
  output logic        done,
  output logic [31:0] ld_word_lo,
  output logic [31:0] ld_word_hi,
  output logic        misalign_exc
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ1  = 3'd1,
    S_WAIT1 = 3'd2,
    S_REQ2  = 3'd3,
    S_WAIT2 = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  len_q;
  logic        we_q;
  logic        split_q;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      `MA_LEN_1B: return 3'd1;
      `MA_LEN_2B: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] len_mask(input logic [1:0] len);
    case (len)
      `MA_LEN_1B: return 4'b0001;
      `MA_LEN_2B: return 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

  function automatic logic crosses_word(input logic [1:0] low, input logic [1:0] len);
    return ({1'b0, low} + len_bytes(len)) > 3'd4;
  endfunction

  // Lanes shifted past bit 3 belong to the second word; the 4-bit result
  // drops them here and second_be picks them up.
  function automatic logic [3:0] first_be(input logic [1:0] low, input logic [1:0] len);
    return len_mask(len) << low;
  endfunction

  function automatic logic [3:0] second_be(input logic [1:0] low, input logic [1:0] len);
    return len_mask(len) >> (3'd4 - {1'b0, low});
  endfunction

  function automatic logic [31:0] first_wdata(input logic [1:0] low, input logic [31:0] wd);
    return wd << {low, 3'b000};
  endfunction

  function automatic logic [31:0] second_wdata(input logic [1:0] low, input logic [31:0] wd);
    return wd >> (6'd32 - {1'b0, low, 3'b000});
  endfunction

  logic        req_split;
  logic        trap_now;
  logic [31:0] addr2;
  logic [3:0]  be2;
  logic [31:0] wdata2;

  assign req_split = crosses_word(req_addr[1:0], req_len);

`ifdef MA_MISALIGN_TRAP_EN
  assign trap_now = req_split;
`else
  assign trap_now = 1'b0;
  assign misalign_exc = 1'b0;
`endif

  // Second word address wraps at the top of the 32-bit space.
  assign addr2  = {addr_q[31:2] + 30'd1, 2'b00};
  assign be2    = we_q ? second_be(addr_q[1:0], len_q) : 4'b1111;
  assign wdata2 = we_q ? second_wdata(addr_q[1:0], wdata_q) : 32'd0;

  assign ma_stall = req_valid & ~done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      len_q      <= '0;
      we_q       <= 1'b0;
      split_q    <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      ma_second  <= 1'b0;
      ld_word_lo <= '0;
      ld_word_hi <= '0;
`ifdef MA_MISALIGN_TRAP_EN
      misalign_exc <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            len_q      <= req_len;
            we_q       <= req_we;
            split_q    <= req_split;
            ld_word_hi <= '0;
            if (trap_now) begin
              state <= S_RESP;
              done  <= 1'b1;
`ifdef MA_MISALIGN_TRAP_EN
              misalign_exc <= 1'b1;
`endif
            end else begin
              state     <= S_REQ1;
              mem_req   <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_we    <= req_we;
              mem_be    <= req_we ? first_be(req_addr[1:0], req_len) : 4'b1111;
              mem_wdata <= req_we ? first_wdata(req_addr[1:0], req_wdata) : 32'd0;
            end
          end
        end

        S_REQ1: begin
          if (mem_gnt) begin
            if (!we_q) begin
              state   <= S_WAIT1;
              mem_req <= 1'b0;
              mem_be  <= '0;
            end else if (split_q) begin
              state     <= S_REQ2;
              mem_req   <= 1'b1;
              mem_addr  <= addr2;
              mem_be    <= be2;
              mem_wdata <= wdata2;
            end else begin
              state   <= S_RESP;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              mem_be  <= '0;
              done    <= 1'b1;
            end
          end
        end

        S_WAIT1: begin
          if (mem_rvalid) begin
            ld_word_lo <= mem_rdata;
            if (split_q) begin
              state     <= S_REQ2;
              mem_req   <= 1'b1;
              mem_addr  <= addr2;
              mem_we    <= 1'b0;
              mem_be    <= be2;
              mem_wdata <= wdata2;
            end else begin
              state <= S_RESP;
              done  <= 1'b1;
            end
          end
        end

        S_REQ2: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= '0;
            if (we_q) begin
              state <= S_RESP;
              done  <= 1'b1;
            end else begin
              state     <= S_WAIT2;
              ma_second <= 1'b1;
            end
          end
        end

        S_WAIT2: begin
          if (mem_rvalid) begin
            ld_word_hi <= mem_rdata;
            state      <= S_RESP;
            done       <= 1'b1;
          end
        end

        S_RESP: begin
          state     <= S_IDLE;
          ma_second <= 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
          misalign_exc <= 1'b0;
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ma_access_ctrl.sv
`timescale 1ns/1ps
module tb_ma_access_ctrl;

  localparam logic [1:0] LEN_1B  = 2'd0;
  localparam logic [1:0] LEN_2B  = 2'd1;
  localparam logic [1:0] LEN_4B  = 2'd2;
  localparam logic [1:0] LEN_RSV = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_len = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        ma_stall;
  logic        ma_second;
  logic        done;
  logic [31:0] ld_word_lo;
  logic [31:0] ld_word_hi;
  logic        misalign_exc;

  always #5 clk = ~clk;

  ma_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ma_stall(ma_stall), .ma_second(ma_second), .done(done),
    .ld_word_lo(ld_word_lo), .ld_word_hi(ld_word_hi),
    .misalign_exc(misalign_exc)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } tx_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        second;
    logic        exc;
    int          lat;
  } cpl_t;

  tx_t         exp_tx[$];
  cpl_t        exp_cpl[$];
  logic [31:0] rdata_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cycle_cnt = 0;
  int start_cyc = 0;
  int gnt_delay = 0;
  int rv_delay = 0;
  int wait_cnt = 0;
  int rv_wait = -1;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_tx(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d);
    tx_t t;
    t.addr = a; t.we = w; t.be = b; t.wdata = d;
    exp_tx.push_back(t);
  endtask

  task automatic push_cpl(input logic [31:0] lo, input logic [31:0] hi, input logic sec,
                          input logic exc, input int lat);
    cpl_t c;
    c.lo = lo; c.hi = hi; c.second = sec; c.exc = exc; c.lat = lat;
    exp_cpl.push_back(c);
  endtask

  // Memory model: grants after gnt_delay waiting cycles, returns read data
  // rv_delay cycles after the cycle following a load grant.
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; wait_cnt = 0; rv_wait = -1;
        continue;
      end
      mem_rvalid = 1'b0;
      if (rv_wait == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'hBAD0BAD0;
        rv_wait    = -1;
      end else if (rv_wait > 0) begin
        rv_wait--;
      end
      if (mem_req) begin
        if (wait_cnt >= gnt_delay) begin
          mem_gnt  = 1'b1;
          wait_cnt = 0;
          if (!mem_we) rv_wait = rv_delay;
        end else begin
          mem_gnt = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_gnt  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: checks every presented bus request against the head of the
  // expected transaction queue, and every done pulse against the expected
  // completion.
  initial begin
    logic prev_done;
    cpl_t c;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_done = 1'b0;
        continue;
      end
      if (mem_req) begin
        if (req_valid) chk("stall_busy", ma_stall, 1'b1);
        if (exp_tx.size() == 0) begin
          chk("unexpected_req", mem_req, 1'b0);
        end else begin
          chk("tx_addr", mem_addr, exp_tx[0].addr);
          chk("tx_we", mem_we, exp_tx[0].we);
          chk("tx_be", mem_be, exp_tx[0].be);
          chk("tx_wdata", mem_wdata, exp_tx[0].wdata);
          chk("tx_second", ma_second, 1'b0);
          if (mem_gnt) void'(exp_tx.pop_front());
        end
      end
      if (done) begin
        chk("done_width", prev_done, 1'b0);
        chk("stall_done", ma_stall, 1'b0);
        if (exp_cpl.size() == 0) begin
          chk("unexpected_done", done, 1'b0);
        end else begin
          c = exp_cpl.pop_front();
          chk("ld_word_lo", ld_word_lo, c.lo);
          chk("ld_word_hi", ld_word_hi, c.hi);
          chk("ma_second", ma_second, c.second);
          chk("misalign_exc", misalign_exc, c.exc);
          // Latency counts the request cycle as cycle 1.
          chk("latency", cycle_cnt - start_cyc + 1, c.lat);
        end
      end
      prev_done = done;
    end
  end

  task automatic start_req(input logic we, input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] wdata, input int gd, input int rd);
    @(posedge clk); #1;
    gnt_delay = gd;
    rv_delay  = rd;
    req_we    = we;
    req_addr  = addr;
    req_len   = len;
    req_wdata = wdata;
    req_valid = 1'b1;
    start_cyc = cycle_cnt;
    #1;
    chk("stall_accept", ma_stall, 1'b1);
  endtask

  task automatic finish_req(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no done within 60 cycles", name);
    end
    req_valid = 1'b0;
  endtask

  task automatic reset_and_check(input string tag);
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk({tag, "/mem_req"}, mem_req, 1'b0);
    chk({tag, "/mem_addr"}, mem_addr, 32'd0);
    chk({tag, "/mem_we"}, mem_we, 1'b0);
    chk({tag, "/mem_be"}, mem_be, 4'd0);
    chk({tag, "/mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "/done"}, done, 1'b0);
    chk({tag, "/ma_second"}, ma_second, 1'b0);
    chk({tag, "/misalign_exc"}, misalign_exc, 1'b0);
    chk({tag, "/ld_word_lo"}, ld_word_lo, 32'd0);
    chk({tag, "/ld_word_hi"}, ld_word_hi, 32'd0);
    exp_tx.delete();
    exp_cpl.delete();
    rdata_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    #2;
    reset_and_check("por");

    // Aligned LW 0x100
    push_tx(32'h100, 1'b0, 4'b1111, 32'h0);
    rdata_q.push_back(32'hDEADBEEF);
    push_cpl(32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 4);
    start_req(1'b0, 32'h100, LEN_4B, 32'h0, 0, 0);
    finish_req("lw_aligned");

    // Split LW 0x103
`ifdef MA_MISALIGN_TRAP_EN
    push_cpl(32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 2);
`else
    push_tx(32'h100, 1'b0, 4'b1111, 32'h0);
    push_tx(32'h104, 1'b0, 4'b1111, 32'h0);
    rdata_q.push_back(32'h11223344);
    rdata_q.push_back(32'h55667788);
    push_cpl(32'h11223344, 32'h55667788, 1'b1, 1'b0, 6);
`endif
    start_req(1'b0, 32'h103, LEN_4B, 32'h0, 0, 0);
    finish_req("lw_split");

    // Split SH 0x203
`ifdef MA_MISALIGN_TRAP_EN
    push_cpl(32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 2);
`else
    push_tx(32'h200, 1'b1, 4'b1000, 32'hCD000000);
    push_tx(32'h204, 1'b1, 4'b0001, 32'h000000AB);
    push_cpl(32'h11223344, 32'h0, 1'b0, 1'b0, 4);
`endif
    start_req(1'b1, 32'h203, LEN_2B, 32'h0000ABCD, 0, 0);
    finish_req("sh_split");

    // LB 0x1FF, grant withheld 3 cycles
    push_tx(32'h1FC, 1'b0, 4'b1111, 32'h0);
    rdata_q.push_back(32'hA5B6C7D8);
    push_cpl(32'hA5B6C7D8, 32'h0, 1'b0, 1'b0, 7);
    start_req(1'b0, 32'h1FF, LEN_1B, 32'h0, 3, 0);
    finish_req("lb_gnt_wait");

`ifdef MA_MISALIGN_TRAP_EN
    // Trapped LW 0x102: no bus traffic, done + exception 2 cycles in
    push_cpl(32'hA5B6C7D8, 32'h0, 1'b0, 1'b1, 2);
    start_req(1'b0, 32'h102, LEN_4B, 32'h0, 0, 0);
    finish_req("lw_trap");
    reset_and_check("idle_rst");
`else
    // Split LW 0x0FE, reset while the second word is outstanding
    push_tx(32'h0FC, 1'b0, 4'b1111, 32'h0);
    push_tx(32'h100, 1'b0, 4'b1111, 32'h0);
    rdata_q.push_back(32'h01010101);
    rdata_q.push_back(32'h02020202);
    start_req(1'b0, 32'h0FE, LEN_4B, 32'h0, 0, 3);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ma_second) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wait2_reached", seen, 1'b1);
    chk("both_tx_issued", exp_tx.size(), 0);
    reset_and_check("mid_rst");
`endif

    // Aligned SW after reset
    push_tx(32'h300, 1'b1, 4'b1111, 32'h12345678);
    push_cpl(32'h0, 32'h0, 1'b0, 1'b0, 3);
    start_req(1'b1, 32'h300, LEN_4B, 32'h12345678, 0, 0);
    finish_req("sw_aligned");

    // SB 0x301
    push_tx(32'h300, 1'b1, 4'b0010, 32'h0000EE00);
    push_cpl(32'h0, 32'h0, 1'b0, 1'b0, 3);
    start_req(1'b1, 32'h301, LEN_1B, 32'h000000EE, 0, 0);
    finish_req("sb_301");

    // SH 0x306
    push_tx(32'h304, 1'b1, 4'b1100, 32'hBEEF0000);
    push_cpl(32'h0, 32'h0, 1'b0, 1'b0, 3);
    start_req(1'b1, 32'h306, LEN_2B, 32'h0000BEEF, 0, 0);
    finish_req("sh_306");

    // SB 0x303: low + n == 4, not split
    push_tx(32'h300, 1'b1, 4'b1000, 32'hEE000000);
    push_cpl(32'h0, 32'h0, 1'b0, 1'b0, 3);
    start_req(1'b1, 32'h303, LEN_1B, 32'h000000EE, 0, 0);
    finish_req("sb_303");

    // LH 0x102: low + n == 4, not split
    push_tx(32'h100, 1'b0, 4'b1111, 32'h0);
    rdata_q.push_back(32'h0000CAFE);
    push_cpl(32'h0000CAFE, 32'h0, 1'b0, 1'b0, 4);
    start_req(1'b0, 32'h102, LEN_2B, 32'h0, 0, 0);
    finish_req("lh_102");

    // Reserved length code acts as 4B: split store at 0x401
`ifdef MA_MISALIGN_TRAP_EN
    push_cpl(32'h0000CAFE, 32'h0, 1'b0, 1'b1, 2);
`else
    push_tx(32'h400, 1'b1, 4'b1110, 32'hBBCCDD00);
    push_tx(32'h404, 1'b1, 4'b0001, 32'h000000AA);
    push_cpl(32'h0000CAFE, 32'h0, 1'b0, 1'b0, 4);
`endif
    start_req(1'b1, 32'h401, LEN_RSV, 32'hAABBCCDD, 0, 0);
    finish_req("sw_rsv_split");

    // Split LH at the top of the address space wraps to 0
`ifdef MA_MISALIGN_TRAP_EN
    push_cpl(32'h0000CAFE, 32'h0, 1'b0, 1'b1, 2);
`else
    push_tx(32'hFFFFFFFC, 1'b0, 4'b1111, 32'h0);
    push_tx(32'h00000000, 1'b0, 4'b1111, 32'h0);
    rdata_q.push_back(32'h11111111);
    rdata_q.push_back(32'h22222222);
    push_cpl(32'h11111111, 32'h22222222, 1'b1, 1'b0, 6);
`endif
    start_req(1'b0, 32'hFFFFFFFF, LEN_2B, 32'h0, 0, 0);
    finish_req("lh_wrap");

    // req_valid dropped after acceptance: access still completes
    push_tx(32'h500, 1'b0, 4'b1111, 32'h0);
    rdata_q.push_back(32'h5A5A5A5A);
    push_cpl(32'h5A5A5A5A, 32'h0, 1'b0, 1'b0, 4);
    start_req(1'b0, 32'h500, LEN_4B, 32'h0, 0, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    finish_req("lw_drop_valid");

    repeat (3) @(posedge clk);
    #1;
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("cpl_queue_empty", exp_cpl.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
